// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// MEM_DEPTH_DEFAULT is also the processor bench's instruction memory depth.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        RUN    = 3'd5,
        ERR    = 3'd6
    } load_state_t;

    localparam int unsigned MEM_DEPTH_DEFAULT = 1024;

endpackage

// File: rtl/prog_loader_frame_checksum.sv
// 8-bit modular checksum accumulator for loader frames.
// sum_zero reports whether the running sum plus the byte on din wraps to zero.
module frame_checksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] din,
    output logic [7:0] sum,
    output logic       sum_zero
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + din;
        end
    end

    always_comb begin
        sum_zero = ((sum + din) == 8'd0);
    end

endmodule

// File: rtl/prog_loader.sv
// Loads a framed byte stream (16-bit BE length, payload, checksum) into
// instruction memory and holds the core in reset until a good frame lands.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    load_state_t state, state_n;
    logic [15:0] len_q;
    logic [15:0] count_q;
    logic [15:0] len_full;
    logic [7:0]  csum_sum;
    logic        csum_ok;
    logic        accept;
    logic        clr;
    logic        wr;
    logic        load_hi;
    logic        load_lo;

    frame_checksum u_csum (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .add_en   (wr),
        .din      (rx_data),
        .sum      (csum_sum),
        .sum_zero (csum_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        busy       = (state == LEN_HI) || (state == LEN_LO) ||
                     (state == DATA)   || (state == CSUM);
        rx_ready   = busy;
        done       = (state == RUN);
        err        = (state == ERR);
        core_rst_n = (state == RUN);
    end

    assign accept   = rx_valid && rx_ready;
    assign len_full = {len_q[15:8], rx_data};

    always_comb begin
        state_n = state;
        clr     = 1'b0;
        wr      = 1'b0;
        load_hi = 1'b0;
        load_lo = 1'b0;
        case (state)
            IDLE, RUN, ERR: begin
                if (start) begin
                    state_n = LEN_HI;
                    clr     = 1'b1;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    load_hi = 1'b1;
                    state_n = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    load_lo = 1'b1;
                    if (len_full == 16'd0) begin
                        state_n = CSUM;
                    end else if (len_full > 16'(MEM_DEPTH)) begin
                        state_n = ERR;
                    end else begin
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    wr = 1'b1;
                    if ((count_q + 16'd1) == len_q) begin
                        state_n = CSUM;
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    state_n = csum_ok ? RUN : ERR;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Write port is registered: the byte accepted on one edge is presented the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            count_q   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= wr;
            if (wr) begin
                mem_addr  <= count_q[ADDR_W-1:0];
                mem_wdata <= rx_data;
            end
            if (clr) begin
                count_q <= '0;
            end else if (wr) begin
                count_q <= count_q + 16'd1;
            end
            if (load_hi) begin
                len_q[15:8] <= rx_data;
            end
            if (load_lo) begin
                len_q[7:0] <= rx_data;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as payload
// bytes are driven and matched against mem_we pulses at the negative edge.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       core_rst_n;
    logic       busy;
    logic       done;
    logic       err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned we_count = 0;
    int unsigned last_addr = 0;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] tb_mem[0:1023];
    logic [7:0] payload[0:1023];

    prog_loader #(.MEM_DEPTH(1024), .ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_count++;
            last_addr = mem_addr;
            tb_mem[mem_addr] = mem_wdata;
            if (sb.size() == 0) begin
                check_eq("spurious_we", {31'd0, mem_we}, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check_eq("wr_addr", {22'd0, mem_addr}, {22'd0, e.addr});
                check_eq("wr_data", {24'd0, mem_wdata}, {24'd0, e.data});
            end
        end
    end

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                rx_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!rx_ready) begin
            check_eq("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [7:0] good_csum(input int unsigned len);
        logic [7:0] s;
        s = 8'd0;
        for (int unsigned i = 0; i < len; i++) s = s + payload[i];
        return 8'd0 - s;
    endfunction

    task automatic send_frame(input int unsigned len, input logic [7:0] csum, input bit gaps);
        logic [15:0] l;
        l = len[15:0];
        start_pulse();
        send_byte(l[15:8], gaps);
        send_byte(l[7:0], gaps);
        if (len > 1024) begin
            rx_valid = 1'b0;
            return;
        end
        for (int unsigned i = 0; i < len; i++) begin
            sb.push_back(wr_t'{addr: i[9:0], data: payload[i]});
            send_byte(payload[i], gaps);
        end
        check_eq("core_rst_n_pre_csum", {31'd0, core_rst_n}, 32'd0);
        send_byte(csum, gaps);
        rx_valid = 1'b0;
        check_eq("sb_drained", sb.size(), 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rx_ready",   {31'd0, rx_ready},   32'd0);
        check_eq("rst_mem_we",     {31'd0, mem_we},     32'd0);
        check_eq("rst_mem_addr",   {22'd0, mem_addr},   32'd0);
        check_eq("rst_mem_wdata",  {24'd0, mem_wdata},  32'd0);
        check_eq("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        check_eq("rst_flags",      {29'd0, busy, done, err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: reference frame
        payload[0] = 8'h24; payload[1] = 8'h08; payload[2] = 8'h00; payload[3] = 8'h05;
        we_count = 0;
        send_frame(4, 8'hCF, 1'b0);
        check_eq("t1_done",       {31'd0, done},       32'd1);
        check_eq("t1_core_rst_n", {31'd0, core_rst_n}, 32'd1);
        check_eq("t1_err",        {31'd0, err},        32'd0);
        check_eq("t1_we_count",   we_count,            32'd4);

        // 2: bad checksum, then recovery
        we_count = 0;
        send_frame(4, 8'hCE, 1'b0);
        check_eq("t2_err",        {31'd0, err},        32'd1);
        check_eq("t2_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        check_eq("t2_we_count",   we_count,            32'd4);
        send_frame(4, 8'hCF, 1'b0);
        check_eq("t2_recover_done", {31'd0, done}, 32'd1);

        // 3: zero length and oversize length
        we_count = 0;
        send_frame(0, 8'h00, 1'b0);
        check_eq("t3_zero_done", {31'd0, done}, 32'd1);
        send_frame(1025, 8'h00, 1'b0);
        check_eq("t3_big_err",      {31'd0, err},      32'd1);
        check_eq("t3_big_busy",     {31'd0, busy},     32'd0);
        check_eq("t3_big_rx_ready", {31'd0, rx_ready}, 32'd0);
        check_eq("t3_we_count",     we_count,          32'd0);

        // 4: gapped valid across random payload
        for (int i = 0; i < 4; i++) payload[i] = 8'($urandom_range(0, 255));
        we_count = 0;
        send_frame(4, good_csum(4), 1'b1);
        check_eq("t4_done",     {31'd0, done}, 32'd1);
        check_eq("t4_we_count", we_count,      32'd4);

        // 5a: start while busy is ignored
        we_count = 0;
        start_pulse();
        send_byte(8'h00, 1'b0);
        send_byte(8'h04, 1'b0);
        for (int unsigned i = 0; i < 4; i++) begin
            sb.push_back(wr_t'{addr: i[9:0], data: payload[i]});
            start = (i == 1);
            send_byte(payload[i], 1'b0);
            start = 1'b0;
        end
        send_byte(good_csum(4), 1'b0);
        rx_valid = 1'b0;
        check_eq("t5_start_ignored_done", {31'd0, done}, 32'd1);
        check_eq("t5_we_count",           we_count,      32'd4);

        // 5b: reset mid-load after two payload bytes
        start_pulse();
        send_byte(8'h00, 1'b0);
        send_byte(8'h04, 1'b0);
        for (int unsigned i = 0; i < 2; i++) begin
            sb.push_back(wr_t'{addr: i[9:0], data: payload[i]});
            send_byte(payload[i], 1'b0);
        end
        rx_data = payload[2];
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("t5_rst_rx_ready",   {31'd0, rx_ready},   32'd0);
        check_eq("t5_rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        check_eq("t5_rst_mem_we",     {31'd0, mem_we},     32'd0);
        check_eq("t5_rst_busy",       {31'd0, busy},       32'd0);
        check_eq("t5_rst_sb",         sb.size(),           32'd0);
        @(posedge clk); #1;
        check_eq("t5_idle_ignores_valid", {29'd0, busy, done, err}, 32'd0);
        rx_valid = 1'b0;

        // 6: full-depth frame, one byte per cycle
        for (int i = 0; i < 1024; i++) payload[i] = 8'($urandom_range(0, 255));
        we_count = 0;
        send_frame(1024, good_csum(1024), 1'b0);
        check_eq("t6_done",       {31'd0, done},       32'd1);
        check_eq("t6_core_rst_n", {31'd0, core_rst_n}, 32'd1);
        check_eq("t6_we_count",   we_count,            32'd1024);
        check_eq("t6_last_addr",  last_addr,           32'd1023);
        for (int i = 0; i < 4; i++) begin
            check_eq("t6_fetch", {24'd0, tb_mem[i]}, {24'd0, payload[i]});
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
